// File: rtl/fb_pkg.sv
// Shared definitions for the double-buffered frame store.
// Holds default geometry/colour constants, the fill engine state encoding
// and the coordinate-to-linear-address helpers used by the top and the bench.
package fb_pkg;

    localparam int unsigned FB_H_RES_DEF   = 640;
    localparam int unsigned FB_V_RES_DEF   = 480;
    localparam int unsigned FB_COORD_W_DEF = 10;
    localparam int unsigned FB_PIXEL_W_DEF = 24;

    // Fill engine states
    typedef enum logic {
        FB_IDLE = 1'b0,
        FB_FILL = 1'b1
    } fb_state_e;

    // Row-major linear address of pixel (x, y)
    function automatic int unsigned fb_xy_to_addr(
        input int unsigned x,
        input int unsigned y,
        input int unsigned h_res
    );
        return (y * h_res) + x;
    endfunction

    // True when (x, y) lies inside the visible frame
    function automatic logic fb_in_range(
        input int unsigned x,
        input int unsigned y,
        input int unsigned h_res,
        input int unsigned v_res
    );
        return (x < h_res) && (y < v_res);
    endfunction

endpackage

// File: rtl/fb_bank.sv
// Simple dual-port frame bank: one synchronous write port and one registered
// read port. The read register clears to zero when re is low so the top can
// OR the two bank outputs together without a select mux.
// Ports:
//   clk, rst_n      clock, async active-low reset (read register only)
//   we/waddr/wdata  write port
//   re/raddr        read request and address
//   rdata           registered read data (zero when re was low)
module fb_bank #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage: contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read, forced to zero when not selected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/dbl_frame_buffer.sv
// Double-buffered frame store between the draw pipeline and scan-out.
// Writes and the fill engine always target the back bank (~front_sel);
// the display reads the front bank with one cycle of latency. Swap requests
// are held until a frame_end on which no fill is running or starting.
// Ports:
//   clk, clear_n                      clock, async active-low reset
//   wr_valid/wr_ready/wr_x/wr_y/wr_color, wr_drop   pixel write port
//   fill_start/fill_color/fill_busy   back-bank clear engine
//   swap_req/frame_end/swap_pending/front_sel       bank swap control
//   rd_en/rd_x/rd_y/rd_color/rd_valid scan-out read port
module dbl_frame_buffer
    import fb_pkg::*;
#(
    parameter int unsigned H_RES   = FB_H_RES_DEF,
    parameter int unsigned V_RES   = FB_V_RES_DEF,
    parameter int unsigned COORD_W = FB_COORD_W_DEF,
    parameter int unsigned PIXEL_W = FB_PIXEL_W_DEF
) (
    input  logic               clk,
    input  logic               clear_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [PIXEL_W-1:0] wr_color,
    output logic               wr_drop,
    input  logic               fill_start,
    input  logic [PIXEL_W-1:0] fill_color,
    output logic               fill_busy,
    input  logic               swap_req,
    input  logic               frame_end,
    output logic               swap_pending,
    output logic               front_sel,
    input  logic               rd_en,
    input  logic [COORD_W-1:0] rd_x,
    input  logic [COORD_W-1:0] rd_y,
    output logic [PIXEL_W-1:0] rd_color,
    output logic               rd_valid
);

    localparam int unsigned NPIX   = H_RES * V_RES;
    localparam int unsigned ADDR_W = $clog2(NPIX);

    // Fill engine state
    fb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [PIXEL_W-1:0] fcol_q, fcol_d;
    logic               fill_we_c;

    // Write/read decode
    logic               wr_fire_c;
    logic               wr_in_c;
    logic               rd_hit_c;
    logic [ADDR_W-1:0]  wr_addr_c;
    logic [ADDR_W-1:0]  rd_addr_c;
    logic               swap_exec_c;

    // Back-bank write port
    logic               bk_we_c;
    logic [ADDR_W-1:0]  bk_waddr_c;
    logic [PIXEL_W-1:0] bk_wdata_c;

    logic [PIXEL_W-1:0] rdata0, rdata1;

    // Coordinate decode
    always_comb begin
        wr_in_c   = fb_in_range(32'(wr_x), 32'(wr_y), H_RES, V_RES);
        rd_hit_c  = rd_en && fb_in_range(32'(rd_x), 32'(rd_y), H_RES, V_RES);
        wr_addr_c = ADDR_W'(fb_xy_to_addr(32'(wr_x), 32'(wr_y), H_RES));
        rd_addr_c = ADDR_W'(fb_xy_to_addr(32'(rd_x), 32'(rd_y), H_RES));
        wr_fire_c = wr_valid && wr_ready;
    end

    // Fill FSM: next state and fill write strobe
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fcol_d    = fcol_q;
        fill_we_c = 1'b0;
        case (state_q)
            FB_IDLE: begin
                if (fill_start) begin
                    state_d = FB_FILL;
                    cnt_d   = '0;
                    fcol_d  = fill_color;
                end
            end
            FB_FILL: begin
                fill_we_c = 1'b1;
                cnt_d     = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(NPIX - 1)) begin
                    state_d = FB_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = FB_IDLE;
            end
        endcase
    end

    // Fill FSM state register; busy/ready are registered from the next state
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= FB_IDLE;
            cnt_q     <= '0;
            fcol_q    <= '0;
            fill_busy <= 1'b0;
            wr_ready  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fcol_q    <= fcol_d;
            fill_busy <= (state_d == FB_FILL);
            wr_ready  <= (state_d != FB_FILL);
        end
    end

    // A fill starting on the same edge claims priority over the swap
    always_comb begin
        swap_exec_c = frame_end && (swap_pending || swap_req)
                      && !fill_busy && !fill_start;
    end

    // Swap control, drop pulse and read-valid pipeline
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            wr_drop      <= 1'b0;
            rd_valid     <= 1'b0;
        end else begin
            if (swap_exec_c) begin
                front_sel    <= ~front_sel;
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
            wr_drop  <= wr_fire_c && !wr_in_c;
            rd_valid <= rd_en;
        end
    end

    // Back-bank write source: fill engine or accepted in-range pixel.
    // wr_ready is low throughout a fill, so the two never collide.
    always_comb begin
        bk_we_c    = fill_we_c || (wr_fire_c && wr_in_c);
        bk_waddr_c = fill_we_c ? cnt_q  : wr_addr_c;
        bk_wdata_c = fill_we_c ? fcol_q : wr_color;
    end

    // Bank 0 is back when bank 1 is displayed, and vice versa
    fb_bank #(
        .DEPTH  (NPIX),
        .ADDR_W (ADDR_W),
        .DATA_W (PIXEL_W)
    ) u_bank0 (
        .clk   (clk),
        .rst_n (clear_n),
        .we    (bk_we_c && front_sel),
        .waddr (bk_waddr_c),
        .wdata (bk_wdata_c),
        .re    (rd_hit_c && !front_sel),
        .raddr (rd_addr_c),
        .rdata (rdata0)
    );

    fb_bank #(
        .DEPTH  (NPIX),
        .ADDR_W (ADDR_W),
        .DATA_W (PIXEL_W)
    ) u_bank1 (
        .clk   (clk),
        .rst_n (clear_n),
        .we    (bk_we_c && !front_sel),
        .waddr (bk_waddr_c),
        .wdata (bk_wdata_c),
        .re    (rd_hit_c && front_sel),
        .raddr (rd_addr_c),
        .rdata (rdata1)
    );

    // Only the selected bank's read register can be non-zero
    assign rd_color = rdata0 | rdata1;

endmodule

// File: tb/tb_dbl_frame_buffer.sv
// Bench for dbl_frame_buffer at 8x4 pixels, 12-bit colour.
module tb_dbl_frame_buffer;

    localparam int HR   = 8;
    localparam int VR   = 4;
    localparam int NPIX = HR * VR;

    logic        clk;
    logic        clear_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_x;
    logic [3:0]  wr_y;
    logic [11:0] wr_color;
    logic        wr_drop;
    logic        fill_start;
    logic [11:0] fill_color;
    logic        fill_busy;
    logic        swap_req;
    logic        frame_end;
    logic        swap_pending;
    logic        front_sel;
    logic        rd_en;
    logic [3:0]  rd_x;
    logic [3:0]  rd_y;
    logic [11:0] rd_color;
    logic        rd_valid;

    dbl_frame_buffer #(
        .H_RES   (HR),
        .V_RES   (VR),
        .COORD_W (4),
        .PIXEL_W (12)
    ) dut (
        .clk          (clk),
        .clear_n      (clear_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_color     (wr_color),
        .wr_drop      (wr_drop),
        .fill_start   (fill_start),
        .fill_color   (fill_color),
        .fill_busy    (fill_busy),
        .swap_req     (swap_req),
        .frame_end    (frame_end),
        .swap_pending (swap_pending),
        .front_sel    (front_sel),
        .rd_en        (rd_en),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_color     (rd_color),
        .rd_valid     (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: two pixel arrays plus which one is displayed
    logic [11:0] mem   [2][NPIX];
    bit          known [2][NPIX];
    int          m_front;
    bit          m_pend;
    int          m_fill_left;
    logic [11:0] m_fill_col;
    bit          m_drop;
    logic [11:0] m_rd;
    bit          m_rd_known;
    bit          m_rdv;

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < NPIX; a++) known[b][a] = 1'b0;
    end

    always @(posedge clk or negedge clear_n) begin
        int  back;
        int  a;
        bit  busy0;
        if (!clear_n) begin
            m_front = 0; m_pend = 0; m_fill_left = 0; m_drop = 0;
            m_rd = '0; m_rd_known = 1; m_rdv = 0; m_fill_col = '0;
        end else begin
            busy0 = (m_fill_left > 0);
            back  = 1 - m_front;
            // display sees the bank that was front before this edge
            m_rdv = rd_en; m_rd = '0; m_rd_known = 1;
            if (rd_en && int'(rd_x) < HR && int'(rd_y) < VR) begin
                a = int'(rd_y) * HR + int'(rd_x);
                m_rd = mem[m_front][a];
                m_rd_known = known[m_front][a];
            end
            m_drop = 0;
            if (wr_valid && !busy0) begin
                if (int'(wr_x) < HR && int'(wr_y) < VR) begin
                    a = int'(wr_y) * HR + int'(wr_x);
                    mem[back][a] = wr_color; known[back][a] = 1;
                end else begin
                    m_drop = 1;
                end
            end
            if (busy0) begin
                a = NPIX - m_fill_left;
                mem[back][a] = m_fill_col; known[back][a] = 1;
                m_fill_left--;
            end else if (fill_start) begin
                m_fill_left = NPIX;
                m_fill_col  = fill_color;
            end
            if (frame_end && (m_pend || swap_req) && !busy0 && !fill_start) begin
                m_front = back; m_pend = 0;
            end else if (swap_req) begin
                m_pend = 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_front_sel",    32'(front_sel),    32'(m_front));
            chk("model_swap_pending", 32'(swap_pending), 32'(m_pend));
            chk("model_fill_busy",    32'(fill_busy),    32'(m_fill_left > 0));
            chk("model_wr_ready",     32'(wr_ready),     32'(m_fill_left == 0));
            chk("model_wr_drop",      32'(wr_drop),      32'(m_drop));
            chk("model_rd_valid",     32'(rd_valid),     32'(m_rdv));
            if (m_rd_known) chk("model_rd_color", 32'(rd_color), 32'(m_rd));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input int x, input int y, input logic [11:0] c);
        wr_valid = 1'b1; wr_x = 4'(x); wr_y = 4'(y); wr_color = c;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic read_px(input int x, input int y);
        rd_en = 1'b1; rd_x = 4'(x); rd_y = 4'(y);
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        int n;
        clear_n = 1'b0; wr_valid = 0; wr_x = 0; wr_y = 0; wr_color = 0;
        fill_start = 0; fill_color = 0; swap_req = 0; frame_end = 0;
        rd_en = 0; rd_x = 0; rd_y = 0;
        step(); step();
        chk_en = 1'b1;
        chk("reset_front_sel", 32'(front_sel), 0);
        chk("reset_wr_ready",  32'(wr_ready), 1);
        chk("reset_fill_busy", 32'(fill_busy), 0);
        chk("reset_rd_color",  32'(rd_color), 0);
        chk("reset_rd_valid",  32'(rd_valid), 0);
        clear_n = 1'b1;
        step();

        // write, deferred swap, read back through the new front bank
        write_px(2, 1, 12'hABC);
        swap_req = 1'b1; step(); swap_req = 1'b0;
        chk("s1_pending_set", 32'(swap_pending), 1);
        chk("s1_front_before", 32'(front_sel), 0);
        frame_end = 1'b1; step(); frame_end = 1'b0;
        chk("s1_front_after", 32'(front_sel), 1);
        chk("s1_pending_clr", 32'(swap_pending), 0);
        read_px(2, 1);
        chk("s1_rd_color", 32'(rd_color), 32'h0ABC);
        chk("s1_rd_valid", 32'(rd_valid), 1);
        step();
        chk("s1_rd_valid_low", 32'(rd_valid), 0);

        // out-of-range write must not alias onto (0,1)
        write_px(0, 1, 12'h555);
        write_px(8, 0, 12'h123);
        chk("s2_drop_pulse", 32'(wr_drop), 1);
        step();
        chk("s2_drop_clear", 32'(wr_drop), 0);

        // request and frame_end together swap immediately
        swap_req = 1'b1; frame_end = 1'b1; step(); swap_req = 1'b0; frame_end = 1'b0;
        chk("s5_front", 32'(front_sel), 0);
        chk("s5_pending", 32'(swap_pending), 0);
        read_px(0, 1);
        chk("s2_bank_unchanged", 32'(rd_color), 32'h0555);
        read_px(8, 0);
        chk("s2_oor_read", 32'(rd_color), 0);

        // fill with swap requested mid-fill, ignored writes and re-starts
        fill_color = 12'h0F0; fill_start = 1'b1; step(); fill_start = 1'b0;
        chk("s3_busy_rise", 32'(fill_busy), 1);
        chk("s3_ready_low", 32'(wr_ready), 0);
        n = 0;
        while (fill_busy === 1'b1 && n < 100) begin
            swap_req   = (n == 5);
            frame_end  = (n == 8);
            fill_start = (n == 10);
            fill_color = (n == 10) ? 12'hFFF : 12'h0F0;
            wr_valid   = (n == 12); wr_x = 4'd3; wr_y = 4'd3; wr_color = 12'hBAD;
            step();
            n++;
            if (n == 9) begin
                chk("s4_front_held", 32'(front_sel), 0);
                chk("s4_pending_held", 32'(swap_pending), 1);
            end
        end
        swap_req = 0; frame_end = 0; fill_start = 0; wr_valid = 0;
        chk("s3_busy_cycles", 32'(n), 32);
        chk("s4_pending_after_fill", 32'(swap_pending), 1);
        frame_end = 1'b1; step(); frame_end = 1'b0;
        chk("s4_front_toggle", 32'(front_sel), 1);
        for (int a = 0; a < NPIX; a++) begin
            read_px(a % HR, a / HR);
            chk($sformatf("s3_fill_px%0d", a), 32'(rd_color), 32'h00F0);
        end

        // fill_start beats a pending swap on frame_end, then reset mid-fill
        swap_req = 1'b1; step(); swap_req = 1'b0;
        fill_color = 12'h00F; fill_start = 1'b1; frame_end = 1'b1;
        step();
        fill_start = 1'b0; frame_end = 1'b0;
        chk("s6_front_deferred", 32'(front_sel), 1);
        chk("s6_pending_kept", 32'(swap_pending), 1);
        chk("s6_busy", 32'(fill_busy), 1);
        repeat (10) step();
        clear_n = 1'b0;
        #1;
        chk("s7_busy_async", 32'(fill_busy), 0);
        chk("s7_front_async", 32'(front_sel), 0);
        chk("s7_pending_async", 32'(swap_pending), 0);
        step();
        clear_n = 1'b1;
        step();
        chk("s7_ready_after", 32'(wr_ready), 1);
        chk("s7_busy_after", 32'(fill_busy), 0);

        // bank0 now front: first ten pixels filled, rest untouched by the fill
        for (int a = 0; a < 12; a++) begin
            read_px(a % HR, a / HR);
            if (a < 10) chk($sformatf("s7_partial_px%0d", a), 32'(rd_color), 32'h000F);
        end
        step();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dbl_frame_buffer.md
# dbl_frame_buffer

Parametrised double-buffered frame store between the draw pipeline (writer) and the scan-out/VGA timing logic (reader). Writers always target the back bank. The display always reads the front bank with one-cycle registered latency. Swaps are requested at any time but take effect only on a frame boundary. A built-in fill engine clears the back bank to a programmable colour at one pixel per cycle.

## Interface
- H_RES, 640, horizontal pixels per frame
- V_RES, 480, lines per frame
- COORD_W, 10, width of x/y coordinate ports (must cover max(H_RES,V_RES)-1)
- PIXEL_W, 24, bits per pixel (packed colour, MSB-first R,G,B)
- ADDR_W (localparam), clog2(H_RES*V_RES), linear bank address width

Ports:
- clk  in  1  single clock, rising edge
- clear_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  pixel write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_x, wr_y  in  COORD_W  write coordinate
- wr_color  in  PIXEL_W  write data
- wr_drop  out  1  one-cycle pulse: accepted write was out of range and discarded
- fill_start  in  1  pulse: fill back bank with fill_color
- fill_color  in  PIXEL_W  sampled on the fill_start edge
- fill_busy  out  1  fill engine active
- swap_req  in  1  pulse: request bank swap at next frame_end
- frame_end  in  1  pulse from scan timing at end of visible frame
- swap_pending  out  1  request latched, not yet executed
- front_sel  out  1  bank currently displayed (0 = bank0)
- rd_en  in  1  display active (draw)
- rd_x, rd_y  in  COORD_W  scan coordinate
- rd_color  out  PIXEL_W  front-bank pixel, registered
- rd_valid  out  1  rd_en delayed one cycle

## Operation
- Address: addr = y*H_RES + x. A coordinate is in range iff x<H_RES and y<V_RES.
- Write: an accepted in-range write stores wr_color at addr in bank ~front_sel. An accepted out-of-range write is not stored and pulses wr_drop.
- wr_ready = ~fill_busy.
- Fill FSM has two states, IDLE and FILL.
  - IDLE→FILL on fill_start. Latch fill_color and counter=0.
  - In FILL, write the latched colour to the back bank at counter, then increment. After writing addr N-1 (N=H_RES*V_RES), return to IDLE.
  - fill_start while in FILL is ignored.
- Swap:
  - swap_req sets swap_pending. A swap_req while pending is a no-op.
  - On a frame_end cycle with (swap_pending || swap_req) && ~fill_busy: front_sel toggles and swap_pending clears.
  - A frame_end during FILL leaves pending set, and the swap executes at the first frame_end after the fill completes.
- Read: rd_color <= (rd_en && in range) ? front[addr] : 0. rd_valid <= rd_en.
- Simultaneous events:
  - A write or fill in the same cycle as a swap edge targets the pre-swap back bank.
  - fill_start together with frame_end + pending: fill wins, swap defers.
- Reset (clear_n low, asynchronous):
  - front_sel=0, swap_pending=0, fill FSM=IDLE, fill_busy=0, wr_ready=1, wr_drop=0, rd_color=0, rd_valid=0.
  - Bank contents are not reset.
  - Reset during FILL aborts the fill, leaving a partially filled bank.

## Timing
- Read latency is 1 cycle: coordinate at edge k produces rd_color after edge k+1.
- Writes are visible in the bank on the cycle after acceptance.
- fill_busy rises on the edge sampling fill_start and stays high exactly N cycles. wr_ready is low for the same N cycles.
- front_sel changes on the frame_end edge. The first read of the new front bank is the coordinate presented on the following cycle.
- swap_pending rises on the edge after swap_req and falls on the executing frame_end edge.
- Throughput is one write and one read per cycle sustained, with no read/write bank conflict by construction.

## Structure
- Shared package fb_pkg holds:
  - default H_RES/V_RES/PIXEL_W constants
  - the fill FSM state enum (FB_IDLE, FB_FILL)
  - the coordinate-to-address function
- Sub-module fb_bank is a simple dual-port RAM (1 write port, 1 registered read port, depth H_RES*V_RES, width PIXEL_W), instantiated twice.
- Bank write-enable and read-data muxing are driven by front_sel.

## Test plan
All scenarios use H_RES=8, V_RES=4, PIXEL_W=12.
- Reset, then write (2,1)=0xABC, swap_req, frame_end, read (2,1) with rd_en → rd_color=0xABC one cycle later, front_sel=1.
- Write (8,0)=0x123 → wr_drop pulses once, bank unchanged. Read (8,0) → rd_color=0.
- fill_start with fill_color=0x0F0 → fill_busy and ~wr_ready held exactly 32 cycles. After a swap, all 32 pixels read 0x0F0.
- swap_req, then frame_end during FILL → front_sel unchanged, swap_pending=1. The next frame_end after fill completes toggles front_sel.
- swap_req and frame_end in the same cycle with no fill → front_sel toggles that edge, swap_pending never observed high.
- Assert clear_n mid-fill at count 10 → fill_busy=0 and front_sel=0 immediately. wr_ready=1 after release.
